// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO iterative divider: FSM state encoding
// and default sizing constants.
package hilo_pkg;

    // Default operand / result width (MIPS GPR width).
    localparam int DIV_WIDTH = 32;

    // Iteration counter width for the default operand width.
    localparam int CNT_WIDTH = $clog2(DIV_WIDTH);

    // Divider sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Trial subtract; when there is no borrow the true difference is below
    // the divisor, so its low WIDTH bits are the whole result.
    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {1'b0, divisor});
        diff    = shifted[WIDTH-1:0] - divisor;
        rem_out = q_bit ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/hilo_divider.sv
// Iterative DIV/DIVU unit with HI (remainder) and LO (quotient) registers.
// Magnitudes are divided one bit per clock; signs are applied in a final
// FIX cycle so every operation takes the same 33 clocks.
module hilo_divider
    import hilo_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_reg;
    logic             qsign_reg;
    logic             rsign_reg;
    logic             dz_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             dbz_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] lo_next;
    logic [WIDTH-1:0] hi_next;

    // Operand magnitudes at issue and sign-corrected results for FIX.
    // A zero divisor forces LO to all ones; HI naturally returns the
    // original dividend because the remainder then equals |dividend|.
    always_comb begin
        dvd_neg = is_signed & dividend[WIDTH-1];
        dvs_neg = is_signed & divisor[WIDTH-1];
        dvd_abs = dvd_neg ? -dividend : dividend;
        dvs_abs = dvs_neg ? -divisor : divisor;
        lo_next = dz_reg ? '1 : (qsign_reg ? -quo_reg : quo_reg);
        hi_next = rsign_reg ? -rem_reg : rem_reg;
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_reg),
        .bit_in  (quo_reg[WIDTH-1]),
        .divisor (dvs_reg),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // Sequencer: capture in IDLE, one quotient bit per RUN cycle, sign fix-up
    // and result registration in FIX.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvs_reg   <= '0;
            qsign_reg <= 1'b0;
            rsign_reg <= 1'b0;
            dz_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dbz_reg   <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        quo_reg   <= dvd_abs;
                        dvs_reg   <= dvs_abs;
                        rem_reg   <= '0;
                        cnt_reg   <= CW'(WIDTH - 1);
                        qsign_reg <= dvd_neg ^ dvs_neg;
                        rsign_reg <= dvd_neg;
                        dz_reg    <= (divisor == '0);
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    rem_reg <= rem_next;
                    quo_reg <= {quo_reg[WIDTH-2:0], q_bit};
                    if (cnt_reg == '0) begin
                        state_reg <= FIX;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                FIX: begin
                    lo_reg    <= lo_next;
                    hi_reg    <= hi_next;
                    dbz_reg   <= dz_reg;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;
    assign div_by_zero = dbz_reg;

endmodule
